// File: rtl/lcd_cmd_decoder_mf.sv
// lcd_cmd_decoder_mf
//   SPI LCD command decoder (ST7735/ILI9341 class). Consumes the byte stream
//   and D/C line from the SPI slave. Tracks the CASET/RASET window and the
//   write pointer. Emits one RGB666 pixel with absolute X/Y coordinates per
//   complete RGB565 (16bpp) or RGB666 (18bpp) pixel.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_spi_data          received byte, qualified by i_spi_rxdone
//   i_spi_rxdone        1-cycle strobe per received byte
//   i_spi_dc            0 = command byte, 1 = parameter/data byte
//   i_spi_csreleased    1-cycle strobe on chip-select release
//   o_pix_valid         1-cycle strobe, o_pix_rgb/x/y valid
//   o_pix_rgb           {R6,G6,B6}
//   o_pix_x, o_pix_y    pixel coordinates
//   o_frame_done        strobe with the last window pixel (XE,YE)
//   o_clr_req           strobe after SWRESET
//   o_disp_on, o_inv_on display / inversion levels
//   o_madctl            last MADCTL argument
//   o_bpp18             1 = 18bpp input format, 0 = 16bpp
module lcd_cmd_decoder_mf #(
  parameter int COORD_W = 16,
  parameter int H_RES   = 320,
  parameter int V_RES   = 240
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_spi_data,
  input  logic               i_spi_rxdone,
  input  logic               i_spi_dc,
  input  logic               i_spi_csreleased,
  output logic               o_pix_valid,
  output logic [17:0]        o_pix_rgb,
  output logic [COORD_W-1:0] o_pix_x,
  output logic [COORD_W-1:0] o_pix_y,
  output logic               o_frame_done,
  output logic               o_clr_req,
  output logic               o_disp_on,
  output logic               o_inv_on,
  output logic [7:0]         o_madctl,
  output logic               o_bpp18
);

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_INVOFF  = 8'h20;
  localparam logic [7:0] CMD_INVON   = 8'h21;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  // Window limits in the 16-bit parameter domain used by CASET/RASET.
  localparam logic [15:0]        H_LIM      = 16'(H_RES - 1);
  localparam logic [15:0]        V_LIM      = 16'(V_RES - 1);
  localparam logic [COORD_W-1:0] XE_RST     = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] YE_RST     = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] COORD_ZERO = COORD_W'(0);
  localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);

  // RGB565 -> RGB666: 5-bit channels are widened by replicating their MSB.
  function automatic logic [17:0] rgb565_to_666(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    return {r5, r5[4], g6, b5, b5[4]};
  endfunction

  // 3 bytes R,G,B -> RGB666: each component keeps its top 6 bits.
  function automatic logic [17:0] rgb888_to_666(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
    return {r[7:2], g[7:2], b[7:2]};
  endfunction

  logic [7:0]         cmd_r;
  logic [3:0]         arg_idx_r;
  logic [1:0]         pix_cnt_r;
  logic [7:0]         byte0_r;
  logic [7:0]         byte1_r;
  logic [15:0]        sh_s_r;
  logic [7:0]         sh_e_hi_r;
  logic [COORD_W-1:0] xs_r, xe_r, ys_r, ye_r;
  logic [COORD_W-1:0] x_r, y_r;

  logic               rx_cmd_s;
  logic               rx_par_s;
  logic               is_wr_s;
  logic               pix_last_s;
  logic [17:0]        pix_rgb_s;
  logic [COORD_W-1:0] nx_x_s, nx_y_s;
  logic               wrap_s;
  logic [15:0]        lim_s;
  logic [15:0]        new_e_s;
  logic [15:0]        clamp_e_s;
  logic               commit_ok_s;

  // Byte qualification, pixel assembly, pointer step and window commit check.
  always_comb begin
    rx_cmd_s    = 1'b0;
    rx_par_s    = 1'b0;
    is_wr_s     = 1'b0;
    pix_last_s  = 1'b0;
    pix_rgb_s   = 18'h0_0000;
    nx_x_s      = x_r;
    nx_y_s      = y_r;
    wrap_s      = 1'b0;
    lim_s       = H_LIM;
    new_e_s     = {sh_e_hi_r, i_spi_data};
    clamp_e_s   = new_e_s;
    commit_ok_s = 1'b0;

    // A CS release in the same cycle discards the byte.
    rx_cmd_s = i_spi_rxdone & ~i_spi_dc & ~i_spi_csreleased;
    rx_par_s = i_spi_rxdone &  i_spi_dc & ~i_spi_csreleased;
    is_wr_s  = (cmd_r == CMD_RAMWR) || (cmd_r == CMD_RAMWRC);

    if (o_bpp18) begin
      pix_last_s = (pix_cnt_r == 2'd2);
      pix_rgb_s  = rgb888_to_666(byte0_r, byte1_r, i_spi_data);
    end else begin
      pix_last_s = (pix_cnt_r == 2'd1);
      pix_rgb_s  = rgb565_to_666(byte0_r, i_spi_data);
    end

    // >= keeps the pointer sane if a committed window shrank below it.
    if (x_r < xe_r) begin
      nx_x_s = x_r + COORD_ONE;
      nx_y_s = y_r;
      wrap_s = 1'b0;
    end else if (y_r < ye_r) begin
      nx_x_s = xs_r;
      nx_y_s = y_r + COORD_ONE;
      wrap_s = 1'b0;
    end else begin
      nx_x_s = xs_r;
      nx_y_s = ys_r;
      wrap_s = 1'b1;
    end

    if (cmd_r == CMD_CASET) begin
      lim_s = H_LIM;
    end else begin
      lim_s = V_LIM;
    end
    commit_ok_s = (sh_s_r <= new_e_s) && (sh_s_r <= lim_s);
    if (new_e_s > lim_s) begin
      clamp_e_s = lim_s;
    end else begin
      clamp_e_s = new_e_s;
    end
  end

  // Command/parameter decoding, mode registers, window, pointer and output strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_valid  <= 1'b0;
      o_pix_rgb    <= 18'h0_0000;
      o_pix_x      <= COORD_ZERO;
      o_pix_y      <= COORD_ZERO;
      o_frame_done <= 1'b0;
      o_clr_req    <= 1'b0;
      o_disp_on    <= 1'b0;
      o_inv_on     <= 1'b0;
      o_madctl     <= 8'h00;
      o_bpp18      <= 1'b0;
      cmd_r        <= CMD_NOP;
      arg_idx_r    <= 4'd0;
      pix_cnt_r    <= 2'd0;
      byte0_r      <= 8'h00;
      byte1_r      <= 8'h00;
      sh_s_r       <= 16'h0000;
      sh_e_hi_r    <= 8'h00;
      xs_r         <= COORD_ZERO;
      xe_r         <= XE_RST;
      ys_r         <= COORD_ZERO;
      ye_r         <= YE_RST;
      x_r          <= COORD_ZERO;
      y_r          <= COORD_ZERO;
    end else begin
      o_pix_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_clr_req    <= 1'b0;
      if (i_spi_csreleased) begin
        cmd_r     <= CMD_NOP;
        arg_idx_r <= 4'd0;
        pix_cnt_r <= 2'd0;
      end else if (rx_cmd_s) begin
        // Any command drops a partially assembled pixel.
        cmd_r     <= i_spi_data;
        arg_idx_r <= 4'd0;
        pix_cnt_r <= 2'd0;
        case (i_spi_data)
          CMD_SWRESET: begin
            o_clr_req <= 1'b1;
            o_disp_on <= 1'b0;
            o_inv_on  <= 1'b0;
            o_madctl  <= 8'h00;
            o_bpp18   <= 1'b0;
            xs_r      <= COORD_ZERO;
            xe_r      <= XE_RST;
            ys_r      <= COORD_ZERO;
            ye_r      <= YE_RST;
            x_r       <= COORD_ZERO;
            y_r       <= COORD_ZERO;
          end
          CMD_DISPOFF: o_disp_on <= 1'b0;
          CMD_DISPON:  o_disp_on <= 1'b1;
          CMD_INVOFF:  o_inv_on  <= 1'b0;
          CMD_INVON:   o_inv_on  <= 1'b1;
          CMD_RAMWR: begin
            x_r <= xs_r;
            y_r <= ys_r;
          end
          default: begin
          end
        endcase
      end else if (rx_par_s) begin
        if (arg_idx_r != 4'd15) begin
          arg_idx_r <= arg_idx_r + 4'd1;
        end
        case (cmd_r)
          CMD_CASET, CMD_RASET: begin
            case (arg_idx_r)
              4'd0: sh_s_r[15:8] <= i_spi_data;
              4'd1: sh_s_r[7:0]  <= i_spi_data;
              4'd2: sh_e_hi_r    <= i_spi_data;
              4'd3: begin
                // Invalid windows are dropped whole; the pointer is not touched.
                if (commit_ok_s) begin
                  if (cmd_r == CMD_CASET) begin
                    xs_r <= COORD_W'(sh_s_r);
                    xe_r <= COORD_W'(clamp_e_s);
                  end else begin
                    ys_r <= COORD_W'(sh_s_r);
                    ye_r <= COORD_W'(clamp_e_s);
                  end
                end
              end
              default: begin
              end
            endcase
          end
          CMD_MADCTL: begin
            if (arg_idx_r == 4'd0) begin
              o_madctl <= i_spi_data;
            end
          end
          CMD_COLMOD: begin
            if (arg_idx_r == 4'd0) begin
              case (i_spi_data[2:0])
                3'b110:  o_bpp18 <= 1'b1;
                3'b101:  o_bpp18 <= 1'b0;
                default: begin
                end
              endcase
            end
          end
          default: begin
            if (is_wr_s) begin
              if (pix_last_s) begin
                o_pix_valid  <= 1'b1;
                o_pix_rgb    <= pix_rgb_s;
                o_pix_x      <= x_r;
                o_pix_y      <= y_r;
                o_frame_done <= wrap_s;
                x_r          <= nx_x_s;
                y_r          <= nx_y_s;
                pix_cnt_r    <= 2'd0;
              end else begin
                if (pix_cnt_r == 2'd0) begin
                  byte0_r <= i_spi_data;
                end else begin
                  byte1_r <= i_spi_data;
                end
                pix_cnt_r <= pix_cnt_r + 2'd1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_cmd_decoder_mf.sv
// Bench for lcd_cmd_decoder_mf: directed byte streams, a behavioural model of
// the decoder, a per-cycle compare process and literal checks on a pixel log.
module tb_lcd_cmd_decoder_mf;
  localparam int CW = 16;
  localparam int HR = 320;
  localparam int VR = 240;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    spi_data = 8'h00;
  logic          rxdone = 1'b0;
  logic          dc = 1'b0;
  logic          csrel = 1'b0;
  logic          pix_valid;
  logic [17:0]   pix_rgb;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          frame_done;
  logic          clr_req;
  logic          disp_on;
  logic          inv_on;
  logic [7:0]    madctl;
  logic          bpp18;

  lcd_cmd_decoder_mf #(.COORD_W(CW), .H_RES(HR), .V_RES(VR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spi_data(spi_data), .i_spi_rxdone(rxdone),
    .i_spi_dc(dc), .i_spi_csreleased(csrel), .o_pix_valid(pix_valid),
    .o_pix_rgb(pix_rgb), .o_pix_x(pix_x), .o_pix_y(pix_y), .o_frame_done(frame_done),
    .o_clr_req(clr_req), .o_disp_on(disp_on), .o_inv_on(inv_on), .o_madctl(madctl),
    .o_bpp18(bpp18)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: window, pointer, current command, argument list, pending pixel bytes.
  int m_cmd, m_idx, m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  int m_arg[4];
  int pq[$];
  // Expected outputs after the next clock edge.
  int e_valid, e_fd, e_clr, e_disp, e_inv, e_madctl, e_bpp18, e_rgb, e_x, e_y;

  typedef struct { int x; int y; int rgb; int fd; } pix_t;
  pix_t plog[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_cmd = 0; m_idx = 0; pq.delete();
    m_xs = 0; m_xe = HR - 1; m_ys = 0; m_ye = VR - 1; m_x = 0; m_y = 0;
    e_valid = 0; e_fd = 0; e_clr = 0; e_disp = 0; e_inv = 0; e_madctl = 0;
    e_bpp18 = 0; e_rgb = 0; e_x = 0; e_y = 0;
  endfunction

  function automatic void model_pixel();
    int r6, g6, b6, v;
    if (e_bpp18 != 0) begin
      r6 = pq[0] / 4; g6 = pq[1] / 4; b6 = pq[2] / 4;
    end else begin
      v  = pq[0] * 256 + pq[1];
      r6 = (v / 2048) * 2 + (v / 2048) / 16;
      g6 = (v / 32) % 64;
      b6 = (v % 32) * 2 + (v % 32) / 16;
    end
    pq.delete();
    e_valid = 1; e_rgb = r6 * 4096 + g6 * 64 + b6; e_x = m_x; e_y = m_y;
    if (m_x < m_xe) m_x++;
    else if (m_y < m_ye) begin m_x = m_xs; m_y++; end
    else begin m_x = m_xs; m_y = m_ys; e_fd = 1; end
  endfunction

  function automatic void model_step(bit r, bit d, int v, bit c);
    int k, s, e, lim;
    e_valid = 0; e_fd = 0; e_clr = 0;
    if (c) begin
      m_cmd = 0; m_idx = 0; pq.delete();
    end else if (r && !d) begin
      m_cmd = v; m_idx = 0; pq.delete();
      case (v)
        'h01: begin
          e_clr = 1; e_disp = 0; e_inv = 0; e_madctl = 0; e_bpp18 = 0;
          m_xs = 0; m_xe = HR - 1; m_ys = 0; m_ye = VR - 1; m_x = 0; m_y = 0;
        end
        'h28: e_disp = 0;
        'h29: e_disp = 1;
        'h20: e_inv = 0;
        'h21: e_inv = 1;
        'h2C: begin m_x = m_xs; m_y = m_ys; end
        default: ;
      endcase
    end else if (r && d) begin
      k = m_idx;
      if (m_idx < 15) m_idx++;
      if ((m_cmd == 'h2A || m_cmd == 'h2B) && k < 4) begin
        m_arg[k] = v;
        if (k == 3) begin
          s = m_arg[0] * 256 + m_arg[1];
          e = m_arg[2] * 256 + m_arg[3];
          lim = (m_cmd == 'h2A) ? HR : VR;
          if (s <= e && s < lim) begin
            if (e > lim - 1) e = lim - 1;
            if (m_cmd == 'h2A) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
          end
        end
      end else if (m_cmd == 'h36 && k == 0) begin
        e_madctl = v;
      end else if (m_cmd == 'h3A && k == 0) begin
        if (v % 8 == 6) e_bpp18 = 1;
        else if (v % 8 == 5) e_bpp18 = 0;
      end else if (m_cmd == 'h2C || m_cmd == 'h3C) begin
        pq.push_back(v);
        if (pq.size() == ((e_bpp18 != 0) ? 3 : 2)) model_pixel();
      end
    end
  endfunction

  // Compare process: every cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("pix_valid", pix_valid, e_valid);
      check("pix_rgb", pix_rgb, e_rgb);
      check("pix_x", pix_x, e_x);
      check("pix_y", pix_y, e_y);
      check("frame_done", frame_done, e_fd);
      check("clr_req", clr_req, e_clr);
      check("disp_on", disp_on, e_disp);
      check("inv_on", inv_on, e_inv);
      check("madctl", madctl, e_madctl);
      check("bpp18", bpp18, e_bpp18);
      if (pix_valid === 1'b1) plog.push_back('{int'(pix_x), int'(pix_y), int'(pix_rgb), int'(frame_done)});
    end
  end

  task automatic tick(input bit r, input bit d, input logic [7:0] v, input bit c);
    @(posedge clk);
    #2;
    rxdone = r; dc = d; spi_data = v; csrel = c;
    if (rst_n) model_step(r, d, int'(v), c);
    else model_reset();
  endtask

  task automatic cmd(input logic [7:0] c);
    tick(1'b1, 1'b0, c, 1'b0);
  endtask

  task automatic par(input logic [7:0] v);
    tick(1'b1, 1'b1, v, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic win(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] a2, input logic [7:0] a3);
    cmd(c); par(a0); par(a1); par(a2); par(a3);
  endtask

  task automatic expect_pix(input int i, input int x, input int y, input int fd);
    if (i < plog.size()) begin
      check($sformatf("log%0d_x", i), plog[i].x, x);
      check($sformatf("log%0d_y", i), plog[i].y, y);
      check($sformatf("log%0d_fd", i), plog[i].fd, fd);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL log%0d_missing: got %0d entries, expected more than %0d", i, plog.size(), i);
    end
  endtask

  task automatic expect_rgb(input int i, input int rgb);
    if (i < plog.size()) check($sformatf("log%0d_rgb", i), plog[i].rgb, rgb);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL log%0d_rgb_missing: got %0d entries", i, plog.size());
    end
  endtask

  int base;

  initial begin
    model_reset();
    chk_en = 1'b1;
    idle(2);
    check("rst_madctl", madctl, 8'h00);
    check("rst_valid", pix_valid, 1'b0);
    @(posedge clk); #2; rst_n = 1'b1;
    idle(1);

    // Modes, then SWRESET clears them and strobes clr_req for one cycle.
    cmd(8'h29); cmd(8'h21); cmd(8'h36); par(8'hA5); idle(1);
    check("disp_on_set", disp_on, 1'b1);
    check("madctl_set", madctl, 8'hA5);
    cmd(8'h01); idle(1);
    check("clr_req_pulse", clr_req, 1'b1);
    check("swreset_disp", disp_on, 1'b0);
    idle(1);
    check("clr_req_once", clr_req, 1'b0);

    // 4x2 window, 8 pixels in 16bpp.
    win(8'h2A, 8'h00, 8'h00, 8'h00, 8'h03);
    win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
    base = plog.size();
    cmd(8'h2C);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin par(8'hF8); par(8'h00); end
      else begin par(8'(k * 37)); par(8'(k * 91)); end
    end
    idle(2);
    check("win4x2_count", plog.size() - base, 8);
    for (int k = 0; k < 8; k++) expect_pix(base + k, k % 4, k / 4, (k == 7) ? 1 : 0);
    expect_rgb(base, 18'h3F000);

    // 18bpp, unsupported COLMOD holds, back to 16bpp.
    cmd(8'h3A); par(8'h66); cmd(8'h3A); par(8'h07); idle(1);
    check("colmod_hold", bpp18, 1'b1);
    base = plog.size();
    cmd(8'h2C); par(8'hFC); par(8'h00); par(8'h04); idle(2);
    expect_pix(base, 0, 0, 0);
    expect_rgb(base, 18'h3F001);
    cmd(8'h3A); par(8'h55);
    base = plog.size();
    cmd(8'h2C); par(8'hF8); par(8'h00); idle(2);
    expect_rgb(base, 18'h3F000);

    // 2x2 window at (5..6, 2..3); extra CASET byte ignored; wrap after 4 pixels.
    cmd(8'h2A); par(8'h00); par(8'h05); par(8'h00); par(8'h06); par(8'hFF);
    win(8'h2B, 8'h00, 8'h02, 8'h00, 8'h03);
    base = plog.size();
    cmd(8'h2C);
    for (int k = 0; k < 5; k++) begin par(8'(16 + k)); par(8'(k)); end
    idle(2);
    expect_pix(base + 0, 5, 2, 0);
    expect_pix(base + 1, 6, 2, 0);
    expect_pix(base + 2, 5, 3, 0);
    expect_pix(base + 3, 6, 3, 1);
    expect_pix(base + 4, 5, 2, 0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    cmd(8'h3C); par(8'h12); par(8'h34); idle(2);
    expect_pix(base + 5, 6, 2, 0);

    // XS > XE rejected: window stays 5..6.
    win(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h05);
    base = plog.size();
    cmd(8'h2C); par(8'h01); par(8'h02); par(8'h03); par(8'h04); idle(2);
    expect_pix(base, 5, 2, 0);
    expect_pix(base + 1, 6, 2, 0);

    // XE beyond panel clamps to 319.
    win(8'h2A, 8'h01, 8'h3E, 8'h02, 8'h00);
    win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
    base = plog.size();
    cmd(8'h2C);
    for (int k = 0; k < 3; k++) begin par(8'hAB); par(8'(k)); end
    idle(2);
    expect_pix(base + 0, 318, 0, 0);
    expect_pix(base + 1, 319, 0, 1);
    expect_pix(base + 2, 318, 0, 0);

    // Half pixel dropped by CS release; RAMWRC uses only the new bytes.
    cmd(8'h2C); par(8'hAA); tick(1'b0, 1'b0, 8'h00, 1'b1);
    base = plog.size();
    cmd(8'h3C); par(8'hF8); par(8'h1F); idle(2);
    check("odd_byte_count", plog.size() - base, 1);
    expect_pix(base, 318, 0, 0);
    expect_rgb(base, 18'h3F03F);

    // Byte arriving together with CS release is discarded.
    cmd(8'h2C); par(8'h12); tick(1'b1, 1'b1, 8'h34, 1'b1); par(8'h56); idle(2);
    check("cs_wins_count", plog.size() - base, 1);

    // Asynchronous reset with the final pixel byte pending.
    cmd(8'h29); cmd(8'h2C); par(8'hF8); par(8'h00);
    #1; rst_n = 1'b0; rxdone = 1'b0; model_reset();
    #1;
    check("arst_disp", disp_on, 1'b0);
    check("arst_x", pix_x, 16'h0000);
    base = plog.size();
    idle(2);
    check("arst_no_strobe", plog.size() - base, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    cmd(8'h2C); par(8'h07); par(8'hE0); idle(2);
    check("post_rst_count", plog.size() - base, 1);
    expect_pix(base, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
